glm_rd_arbiter: RTL
===================

Name: glm_rd_arbiter

Overview:
- Shares the single CCI-P c0 read-request channel among N read requesters inside the GLM AFU, e.g. sample, label and model fetch engines.
- Arbitrates round-robin and throttles on c0TxAlmFull and outstanding-read credits.
- Tags each request's mdata with the requester ID and steers read responses back to their owners.
- Provides a drain handshake so the GLM control FSM can quiesce reads before a reconfiguration or restart.

Parameters:
- N_REQ, 4: number of requesters; 1..16.
- ADDR_W, 42: line-address width, matching the CCI-P line address.
- MAX_OUTSTANDING, 128: global limit on in-flight reads; 1..255.
- PER_REQ_MAX, 64: per-requester limit on in-flight reads; 1..MAX_OUTSTANDING.

Ports:
- clk  in  1  AFU clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester read request valid.
- req_addr  in  N_REQ*ADDR_W  per-requester line address; slice i belongs to requester i.
- req_ready  out  N_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- c0_almfull  in  1  c0TxAlmFull from the FIU path.
- rd_valid  out  1  registered read request toward the c0Tx header builder.
- rd_addr  out  ADDR_W  address of the read request.
- rd_mdata  out  16  request tag: [3:0] is requester ID, [15:4] is 0.
- rsp_valid  in  1  c0Rx read response valid; rspValid && type==read is decoded upstream.
- rsp_mdata  in  16  mdata of the read response.
- rsp_route  out  N_REQ  one-hot response valid per requester, registered.
- drain_req  in  1  level input: stop issuing reads and wait for all in-flight reads to return.
- drained  out  1  high while in DRAINED state.
- outstanding  out  8  global in-flight read count.
- err  out  1  sticky protocol error.

Behaviour:
- Both clk and reset_n are fixed as stated: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs 0: req_ready, rd_valid, rd_addr, rd_mdata, rsp_route, drained, outstanding and err.
  - RR pointer 0; all counters 0; state RUN.
- Reset asserted mid-operation: in-flight reads are forgotten and their later responses are not routed. The owner resets the FIU side together with this block.
- States:
  - RUN: drain_req=1 -> DRAINING.
  - DRAINING: when outstanding==0 and no issue is pending -> DRAINED.
  - DRAINED: drain_req=0 -> RUN.
- Grant condition, combinational in cycle t:
  - state==RUN, c0_almfull==0, outstanding<MAX_OUTSTANDING, and per_cnt[i]<PER_REQ_MAX.
  - Among eligible valid requesters, grant the first at or after the RR pointer, scanning upward with wrap.
  - At most one grant per cycle.
  - After a grant to i, pointer = (i+1) mod N_REQ. With no grant, the pointer holds.
- Issue latency: a grant in cycle t gives rd_valid=1 in cycle t+1, with rd_addr=req_addr[i] and rd_mdata={12'h0, i[3:0]}. rd_valid is a one-cycle pulse per grant, so back-to-back grants produce back-to-back pulses.
- Counters:
  - outstanding and per_cnt[i] increment on the grant cycle.
  - outstanding and per_cnt[id] decrement on rsp_valid, where id=rsp_mdata[3:0].
  - A simultaneous increment and decrement on the same counter leaves it unchanged.
- Response routing: rsp_valid in cycle t gives rsp_route[id]=1 in cycle t+1. Response data is carried on the shared c0Rx bus, which consumers register themselves.
- Error conditions, all set err (sticky until reset):
  - rsp_valid with id>=N_REQ: no route and no decrement.
  - rsp_valid with per_cnt[id]==0: no route and no decrement, which prevents underflow.
- Almost-full: c0_almfull blocks new grants in the same cycle it is seen. A request registered the cycle before still issues, which is legal within the CCI-P almost-full slack.
- Drain:
  - drain_req seen in cycle t blocks grants from cycle t onward.
  - drained goes to 1 the cycle after outstanding reaches 0.
  - drained returns to 0 the cycle after drain_req deasserts.

Optional Feature:
- Macro: GLM_RD_ARB_STATS_EN.
- Defined:
  - Adds per-requester 32-bit issue counters and a 32-bit almfull-stall cycle counter; all saturate at 0xFFFFFFFF.
  - Adds output ports stat_issue (N_REQ*32) and stat_stall (32), all cleared by reset_n.
  - The stall counter counts cycles with any req_valid, state==RUN and c0_almfull==1.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- N_REQ=4, all requesters valid continuously, no almfull -> grants cycle 0,1,2,3,0,1… and rd_mdata[3:0] sequence 0,1,2,3,0…; outstanding climbs by 1 per cycle.
- Only requester 2 valid, PER_REQ_MAX=64, no responses -> exactly 64 issues, then req_ready[2]=0. One response with mdata=2 -> exactly one more issue.
- c0_almfull=1 for 10 cycles with all requesters valid -> no grants during those cycles. rd_valid=1 at most in the first cycle, from the prior grant. Traffic resumes the cycle after almfull drops.
- 5 reads in flight; assert drain_req -> no new grants. Return 5 responses -> outstanding reaches 0 and drained=1 on the next cycle. Deassert drain_req -> drained=0 and issue resumes.
- rsp_valid with mdata=0x0007 and N_REQ=4 -> err=1, rsp_route=0 and outstanding unchanged. Same cycle as a grant -> outstanding +1 only.
- Assert reset_n=0 asynchronously mid-burst -> all outputs 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/glm_rd_arbiter_if.sv
// Requester, c0Tx/c0Rx and drain-control signals of glm_rd_arbiter.
// The master modport is the arbiter side; the slave modport is the surrounding AFU.
interface glm_rd_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 42
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0_almfull;
  logic                    rd_valid;
  logic [ADDR_W-1:0]       rd_addr;
  logic [15:0]             rd_mdata;
  logic                    rsp_valid;
  logic [15:0]             rsp_mdata;
  logic [N_REQ-1:0]        rsp_route;
  logic                    drain_req;
  logic                    drained;
  logic [7:0]              outstanding;
  logic                    err;

  modport master (
    input  req_valid, req_addr, c0_almfull, rsp_valid, rsp_mdata, drain_req,
    output req_ready, rd_valid, rd_addr, rd_mdata, rsp_route, drained, outstanding, err
  );

  modport slave (
    output req_valid, req_addr, c0_almfull, rsp_valid, rsp_mdata, drain_req,
    input  req_ready, rd_valid, rd_addr, rd_mdata, rsp_route, drained, outstanding, err
  );
endinterface

// File: rtl/glm_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel among N_REQ requesters, with credit
// throttling, mdata tagging, response steering and a drain handshake.
// Define GLM_RD_ARB_STATS_EN to add per-requester issue counters and an almfull-stall counter.
module glm_rd_arbiter #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned MAX_OUTSTANDING = 128,
  parameter int unsigned PER_REQ_MAX     = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  glm_rd_arbiter_if.master    bus
`ifdef GLM_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0] stat_issue,
  output logic [31:0]         stat_stall
`endif
);
  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StRun = 2'd0, StDraining = 2'd1, StDrained = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [7:0]        outstanding_q, outstanding_d;
  logic [7:0]        per_cnt_q [N_REQ];
  logic [7:0]        per_cnt_d [N_REQ];
  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        rd_id_q, rd_id_d;
  logic [N_REQ-1:0]  route_q, route_d;
  logic              err_q, err_d;

  logic              grant_en, gnt_any, rsp_ok;
  logic [N_REQ-1:0]  gnt;
  logic [PtrW-1:0]   gnt_idx, rsp_idx;
  logic [3:0]        rsp_id;
  logic              unused_mdata;

  assign rsp_id       = bus.rsp_mdata[3:0];
  assign rsp_idx      = PtrW'(rsp_id);
  assign unused_mdata = ^bus.rsp_mdata[15:4];

  // Responses for unknown IDs or idle requesters are dropped to keep counters from underflowing.
  assign rsp_ok = bus.rsp_valid && (32'(rsp_id) < N_REQ) && (per_cnt_q[rsp_idx] != 8'd0);

  // Reset gates the grant so req_ready drops the moment reset_n falls.
  assign grant_en = reset_n && (state_q == StRun) && !bus.drain_req && !bus.c0_almfull &&
                    (32'(outstanding_q) < MAX_OUTSTANDING);

  always_comb begin
    int unsigned     idx;
    logic [PtrW-1:0] cand;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx  = (32'(ptr_q) + k) % N_REQ;
      cand = PtrW'(idx);
      if (grant_en && !gnt_any && bus.req_valid[cand] &&
          (32'(per_cnt_q[cand]) < PER_REQ_MAX)) begin
        gnt[cand] = 1'b1;
        gnt_any   = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d     = gnt_any ? PtrW'((32'(gnt_idx) + 1) % N_REQ) : ptr_q;
    rd_addr_d = gnt_any ? bus.req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W] : rd_addr_q;
    rd_id_d   = gnt_any ? 4'(gnt_idx) : rd_id_q;
    route_d   = '0;
    if (rsp_ok) route_d[rsp_idx] = 1'b1;
    err_d = err_q | (bus.rsp_valid && !rsp_ok);

    outstanding_d = outstanding_q;
    if (gnt_any && !rsp_ok)      outstanding_d = outstanding_q + 8'd1;
    else if (!gnt_any && rsp_ok) outstanding_d = outstanding_q - 8'd1;

    for (int i = 0; i < N_REQ; i++) begin
      per_cnt_d[i] = per_cnt_q[i];
      if (gnt[i] && !(rsp_ok && rsp_idx == PtrW'(i)))      per_cnt_d[i] = per_cnt_q[i] + 8'd1;
      else if (!gnt[i] && rsp_ok && rsp_idx == PtrW'(i))   per_cnt_d[i] = per_cnt_q[i] - 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (bus.drain_req) state_d = StDraining;
      StDraining: if (outstanding_q == 8'd0 && !rd_valid_q) state_d = StDrained;
      StDrained:  if (!bus.drain_req) state_d = StRun;
      default:    state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      ptr_q         <= '0;
      outstanding_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_id_q       <= '0;
      route_q       <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < N_REQ; i++) per_cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      rd_valid_q    <= gnt_any;
      rd_addr_q     <= rd_addr_d;
      rd_id_q       <= rd_id_d;
      route_q       <= route_d;
      err_q         <= err_d;
      for (int i = 0; i < N_REQ; i++) per_cnt_q[i] <= per_cnt_d[i];
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_mdata    = {12'h000, rd_id_q};
  assign bus.rsp_route   = route_q;
  assign bus.drained     = (state_q == StDrained);
  assign bus.outstanding = outstanding_q;
  assign bus.err         = err_q;

`ifdef GLM_RD_ARB_STATS_EN
  logic [31:0] issue_q [N_REQ];
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (|bus.req_valid) && (state_q == StRun) && bus.c0_almfull;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) issue_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && issue_q[i] != '1) issue_q[i] <= issue_q[i] + 32'd1;
      end
      if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    stat_issue = '0;
    for (int i = 0; i < N_REQ; i++) stat_issue[i*32 +: 32] = issue_q[i];
  end
  assign stat_stall = stall_q;
`endif
endmodule
